// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential IEEE-754 multiplier: rounding modes,
// FSM states, operand classification, canonical NaN and exponent bias.
package fp_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rnd_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } fp_mul_state_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
        logic normal;
    } fp_class_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive sign, all-ones exponent, only the fraction MSB set.
    function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Subnormals classify as zero so the datapath only ever sees a hidden 1.
    function automatic fp_class_t fp_classify(input logic [63:0] exp_f, input logic [63:0] man_f,
                                              input int exp_w, input int man_w);
        fp_class_t c;
        logic      exp_max;
        logic      man_nz;
        logic      msb;
        exp_max  = (exp_f == ((64'd1 << exp_w) - 64'd1));
        man_nz   = |(man_f & ((64'd1 << man_w) - 64'd1));
        msb      = |((man_f >> (man_w - 1)) & 64'd1);
        c.zero   = (exp_f == 64'd0);
        c.inf    = exp_max & ~man_nz;
        c.qnan   = exp_max & man_nz & msb;
        c.snan   = exp_max & man_nz & ~msb;
        c.normal = ~c.zero & ~exp_max;
        return c;
    endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle between the FP ALU decoder (master) and the
// multiplier (slave).
interface fp_mul_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    // A transfer happens on a clock edge where valid and ready are both 1; a
    // producer keeps valid and its payload unchanged until that edge.
    logic           in_valid_i;
    logic           in_ready_o;
    logic [W-1:0]   fp_a_i;
    logic [W-1:0]   fp_b_i;
    logic [2:0]     r_mode_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [W-1:0]   fp_result_o;
    logic           overflow_o;
    logic           underflow_o;
    logic           invalid_o;

    modport slave (
        input  in_valid_i, fp_a_i, fp_b_i, r_mode_i, out_ready_i,
        output in_ready_o, out_valid_o, fp_result_o, overflow_o, underflow_o, invalid_o
    );

    modport master (
        output in_valid_i, fp_a_i, fp_b_i, r_mode_i, out_ready_i,
        input  in_ready_o, out_valid_o, fp_result_o, overflow_o, underflow_o, invalid_o
    );

endinterface

// File: rtl/fp_mul_round.sv
// Combinational back end of the multiplier: 1-bit normalise, guard/round/sticky
// rounding with carry renormalisation, then overflow saturation and FTZ underflow.
module fp_mul_round
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int PW    = 2 * (MAN_W + 1)
) (
    input  logic                    i_sign,
    input  logic [PW-1:0]           i_prod,
    input  logic signed [EXP_W+1:0] i_exp,
    input  logic [2:0]              i_r_mode,
    output logic [W-1:0]            o_result,
    output logic                    o_overflow,
    output logic                    o_underflow
);
    localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W + 2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] ONE_S   = (EXP_W + 2)'(1);

    rnd_mode_e               w_mode;
    logic [PW-1:0]           w_norm;
    logic signed [EXP_W+1:0] w_exp;
    logic signed [EXP_W+1:0] w_exp_r;
    logic [MAN_W:0]          w_man;
    logic [MAN_W+1:0]        w_man_r;
    logic [MAN_W-1:0]        w_frac;
    logic                    w_guard;
    logic                    w_rnd;
    logic                    w_sticky;
    logic                    w_inc;
    logic                    w_carry;
    logic                    w_to_inf;

    always_comb begin
        w_mode   = rnd_mode_e'(i_r_mode);
        // Product of two [1,2) mantissas lies in [1,4): at most one right shift.
        w_norm   = i_prod[PW-1] ? i_prod : (i_prod << 1);
        w_exp    = i_exp + (i_prod[PW-1] ? ONE_S : '0);
        w_man    = w_norm[PW-1 -: MAN_W+1];
        w_guard  = w_norm[MAN_W];
        w_rnd    = w_norm[MAN_W-1];
        w_sticky = |w_norm[MAN_W-2:0];

        case (w_mode)
            RTZ:     w_inc = 1'b0;
            RDN:     w_inc = i_sign & (w_guard | w_rnd | w_sticky);
            RUP:     w_inc = ~i_sign & (w_guard | w_rnd | w_sticky);
            RMM:     w_inc = w_guard;
            default: w_inc = w_guard & (w_rnd | w_sticky | w_man[0]);
        endcase

        w_man_r = {1'b0, w_man} + {{(MAN_W + 1){1'b0}}, w_inc};
        w_carry = w_man_r[MAN_W+1];
        w_frac  = w_carry ? w_man_r[MAN_W:1] : w_man_r[MAN_W-1:0];
        w_exp_r = w_exp + (w_carry ? ONE_S : '0);

        case (w_mode)
            RTZ:     w_to_inf = 1'b0;
            RDN:     w_to_inf = i_sign;
            RUP:     w_to_inf = ~i_sign;
            default: w_to_inf = 1'b1;
        endcase

        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        if (w_exp < ONE_S) begin
            o_underflow = 1'b1;
            o_result    = {i_sign, {(W - 1){1'b0}}};
        end else if (w_exp_r >= EXP_MAX) begin
            o_overflow = 1'b1;
            o_result   = w_to_inf ? {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                  : {i_sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else begin
            o_result = {i_sign, w_exp_r[EXP_W-1:0], w_frac};
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 multiplier with an iterative shift-add mantissa core.
// Define FP_MUL_RADIX4_EN to retire two multiplier bits per MUL cycle.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fp_mul_seq_if.slave   bus,
    output fp_mul_state_e dbg_state_o
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 1;
    localparam int PW   = 2 * MW;
`ifdef FP_MUL_RADIX4_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int ITER = (MW + STEP - 1) / STEP;
    localparam int MPW  = ITER * STEP;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(fp_bias(EXP_W));
    localparam logic [63:0]  NAN64 = canonical_nan(EXP_W, MAN_W);
    localparam logic [W-1:0] NAN_W = NAN64[W-1:0];

    fp_mul_state_e           r_state;
    fp_mul_state_e           w_next;
    logic [PW-1:0]           r_acc;
    logic [PW-1:0]           r_mcand;
    logic [MPW-1:0]          r_mplier;
    logic [CW-1:0]           r_cnt;
    logic [EXP_W-1:0]        r_ea;
    logic [EXP_W-1:0]        r_eb;
    logic signed [EXP_W+1:0] r_exp;
    logic                    r_sign;
    logic [2:0]              r_mode;
    logic [W-1:0]            r_result;
    logic                    r_ovf;
    logic                    r_udf;
    logic                    r_inv;

    logic [EXP_W-1:0]        w_a_exp, w_b_exp;
    logic [MAN_W-1:0]        w_a_man, w_b_man;
    fp_class_t               w_ca, w_cb;
    logic                    w_sign, w_special, w_spec_inv;
    logic [W-1:0]            w_spec_res;
    logic [PW-1:0]           w_pp;
    logic signed [EXP_W+1:0] w_exp_sum;
    logic [W-1:0]            w_rnd_res;
    logic                    w_rnd_ovf, w_rnd_udf;

    always_comb begin
        w_a_exp   = bus.fp_a_i[W-2 -: EXP_W];
        w_b_exp   = bus.fp_b_i[W-2 -: EXP_W];
        w_a_man   = bus.fp_a_i[MAN_W-1:0];
        w_b_man   = bus.fp_b_i[MAN_W-1:0];
        w_ca      = fp_classify(64'(w_a_exp), 64'(w_a_man), EXP_W, MAN_W);
        w_cb      = fp_classify(64'(w_b_exp), 64'(w_b_man), EXP_W, MAN_W);
        w_sign    = bus.fp_a_i[W-1] ^ bus.fp_b_i[W-1];
        w_special = ~(w_ca.normal & w_cb.normal);
        // NaN and Inf*0 take priority over Inf, which takes priority over zero.
        w_spec_inv = 1'b0;
        if (w_ca.qnan | w_ca.snan | w_cb.qnan | w_cb.snan) begin
            w_spec_res = NAN_W;
            w_spec_inv = w_ca.snan | w_cb.snan;
        end else if ((w_ca.inf & w_cb.zero) | (w_ca.zero & w_cb.inf)) begin
            w_spec_res = NAN_W;
            w_spec_inv = 1'b1;
        end else if (w_ca.inf | w_cb.inf) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            w_spec_res = {w_sign, {(W - 1){1'b0}}};
        end
    end

`ifdef FP_MUL_RADIX4_EN
    assign w_pp = (r_mplier[0] ? r_mcand : '0) + (r_mplier[1] ? (r_mcand << 1) : '0);
`else
    assign w_pp = r_mplier[0] ? r_mcand : '0;
`endif
    assign w_exp_sum = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - BIAS_S;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid_i) w_next = w_special ? DONE : MUL;
            MUL:     if (r_cnt == CW'(ITER - 1)) w_next = RND;
            RND:     w_next = DONE;
            DONE:    if (bus.out_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready_o  = (r_state == IDLE);
        bus.out_valid_o = (r_state == DONE);
        bus.fp_result_o = r_result;
        bus.overflow_o  = r_ovf;
        bus.underflow_o = r_udf;
        bus.invalid_o   = r_inv;
        dbg_state_o     = r_state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_mode   <= 3'b000;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid_i) begin
                    r_sign   <= w_sign;
                    r_mode   <= bus.r_mode_i;
                    r_ea     <= w_a_exp;
                    r_eb     <= w_b_exp;
                    r_mcand  <= PW'({1'b1, w_a_man});
                    r_mplier <= MPW'({1'b1, w_b_man});
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_ovf    <= 1'b0;
                        r_udf    <= 1'b0;
                        r_inv    <= w_spec_inv;
                    end
                end
                MUL: begin
                    if (r_cnt == '0) r_exp <= w_exp_sum;
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << STEP;
                    r_mplier <= r_mplier >> STEP;
                    r_cnt    <= r_cnt + 1'b1;
                end
                RND: begin
                    r_result <= w_rnd_res;
                    r_ovf    <= w_rnd_ovf;
                    r_udf    <= w_rnd_udf;
                    r_inv    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .i_sign      (r_sign),
        .i_prod      (r_acc),
        .i_exp       (r_exp),
        .i_r_mode    (r_mode),
        .o_result    (w_rnd_res),
        .o_overflow  (w_rnd_ovf),
        .o_underflow (w_rnd_udf)
    );

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq (binary32): results, flags, latency, backpressure
// and reset abort against hand-computed vectors.
module tb_fp_mul_seq;
    import fp_pkg::*;

`ifdef FP_MUL_RADIX4_EN
    localparam int LAT_N = 14;
`else
    localparam int LAT_N = 26;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    fp_mul_state_e dbg_state;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   res;
    logic [2:0]    flg;
    int            lat;

    fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for IDLE, presents one operand pair, then waits (bounded) for
    // out_valid. lat counts edges from the accept edge, inclusive.
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        int w = 0;
        while (bus.in_ready_o !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        bus.fp_a_i     = a;
        bus.fp_b_i     = b;
        bus.r_mode_i   = m;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        lat = 1;
        while (bus.out_valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = bus.fp_result_o;
        flg = {bus.overflow_o, bus.underflow_o, bus.invalid_o};
    endtask

    task automatic release_out();
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
    endtask

    // Flags expected as {overflow, underflow, invalid}.
    task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] m, input logic [31:0] er, input logic [2:0] ef,
                       input int el);
        op(a, b, m);
        chk({tag, "_res"}, res, er);
        chk({tag, "_flags"}, 32'(flg), 32'(ef));
        chk({tag, "_lat"}, 32'(lat), 32'(el));
        release_out();
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.fp_a_i      = '0;
        bus.fp_b_i      = '0;
        bus.r_mode_i    = 3'b000;
        bus.out_ready_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_result", bus.fp_result_o, 32'h0);
        chk("rst_flags", 32'({bus.overflow_o, bus.underflow_o, bus.invalid_o}), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        vec("basic",     32'h40000000, 32'h40400000, 3'b000, 32'h40C00000, 3'b000, LAT_N);
        vec("rne_sq",    32'h3F800001, 32'h3F800001, 3'b000, 32'h3F800002, 3'b000, LAT_N);
        vec("rtz_sq",    32'h3F800001, 32'h3F800001, 3'b001, 32'h3F800002, 3'b000, LAT_N);
        vec("rup_sq",    32'h3F800001, 32'h3F800001, 3'b011, 32'h3F800003, 3'b000, LAT_N);
        vec("rdn_sq",    32'h3F800001, 32'h3F800001, 3'b010, 32'h3F800002, 3'b000, LAT_N);
        vec("rdn_neg",   32'hBF800001, 32'h3F800001, 3'b010, 32'hBF800003, 3'b000, LAT_N);
        vec("rup_neg",   32'hBF800001, 32'h3F800001, 3'b011, 32'hBF800002, 3'b000, LAT_N);
        vec("tie_rne",   32'h3FC00000, 32'h3F800001, 3'b000, 32'h3FC00002, 3'b000, LAT_N);
        vec("tie_rtz",   32'h3FC00000, 32'h3F800001, 3'b001, 32'h3FC00001, 3'b000, LAT_N);
        vec("tie_rmm",   32'h3FC00000, 32'h3F800001, 3'b100, 32'h3FC00002, 3'b000, LAT_N);
        vec("tie_code5", 32'h3FC00000, 32'h3F800001, 3'b101, 32'h3FC00002, 3'b000, LAT_N);
        vec("carry_rne", 32'h3FFFFFFE, 32'h3F800001, 3'b000, 32'h40000000, 3'b000, LAT_N);
        vec("carry_rtz", 32'h3FFFFFFE, 32'h3F800001, 3'b001, 32'h3FFFFFFF, 3'b000, LAT_N);
        vec("ovf_rne",   32'h7F7FFFFF, 32'h40000000, 3'b000, 32'h7F800000, 3'b100, LAT_N);
        vec("ovf_rtz",   32'h7F7FFFFF, 32'h40000000, 3'b001, 32'h7F7FFFFF, 3'b100, LAT_N);
        vec("ovf_rup_n", 32'hFF7FFFFF, 32'h40000000, 3'b011, 32'hFF7FFFFF, 3'b100, LAT_N);
        vec("ovf_rdn_n", 32'hFF7FFFFF, 32'h40000000, 3'b010, 32'hFF800000, 3'b100, LAT_N);
        vec("ovf_rmm",   32'h7F7FFFFF, 32'h40000000, 3'b100, 32'h7F800000, 3'b100, LAT_N);
        vec("ovf_carry", 32'h7F7FFFFE, 32'h3F800001, 3'b000, 32'h7F800000, 3'b100, LAT_N);
        vec("max_nocar", 32'h7F7FFFFE, 32'h3F800001, 3'b001, 32'h7F7FFFFF, 3'b000, LAT_N);
        vec("udf_pos",   32'h00800000, 32'h3F000000, 3'b000, 32'h00000000, 3'b010, LAT_N);
        vec("udf_neg",   32'h80800000, 32'h3F000000, 3'b000, 32'h80000000, 3'b010, LAT_N);
        vec("udf_deep",  32'h00800000, 32'h00800000, 3'b000, 32'h00000000, 3'b010, LAT_N);
        vec("min_norm",  32'h00800000, 32'h3F800000, 3'b000, 32'h00800000, 3'b000, LAT_N);
        vec("inf_x_zero", 32'h7F800000, 32'h80000000, 3'b000, 32'h7FC00000, 3'b001, 1);
        vec("nzero_x_1", 32'h80000000, 32'h3F800000, 3'b000, 32'h80000000, 3'b000, 1);
        vec("snan",      32'h7F800001, 32'h3F800000, 3'b000, 32'h7FC00000, 3'b001, 1);
        vec("qnan",      32'hFFC00000, 32'h3F800000, 3'b000, 32'h7FC00000, 3'b000, 1);
        vec("ninf_x_2",  32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 3'b000, 1);
        vec("daz",       32'h00000001, 32'h3F800000, 3'b000, 32'h00000000, 3'b000, 1);

        op(32'h40000000, 32'h40400000, 3'b000);
        chk("bp_first", res, 32'h40C00000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_result", bus.fp_result_o, 32'h40C00000);
            chk("bp_valid", 32'(bus.out_valid_o), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
        end
        release_out();
        chk("bp_released", 32'(bus.in_ready_o), 32'd1);

        bus.fp_a_i     = 32'h40000000;
        bus.fp_b_i     = 32'h40400000;
        bus.r_mode_i   = 3'b000;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_in_mul", 32'(dbg_state), 32'(MUL));
        chk("abort_busy", 32'(bus.in_ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", 32'(bus.out_valid_o), 32'd0);
        chk("abort_ready", 32'(bus.in_ready_o), 32'd1);
        chk("abort_result", bus.fp_result_o, 32'h0);
        chk("abort_state", 32'(dbg_state), 32'(IDLE));
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_late", 32'(bus.out_valid_o), 32'd0);
        vec("after_abort", 32'h40400000, 32'h40400000, 3'b000, 32'h41100000, 3'b000, LAT_N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
